// File: rtl/apb_pkg.sv
// apb_pkg: shared types, constants and byte-lane merge helper for the APB register memory.
//   Exports: state_e (IDLE/ACCESS), APB_ADDR_W, MERGE_W/MERGE_B, lsb_of(), byte_merge().
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam int APB_ADDR_W = 32;

    // byte_merge works on a wide carrier so any DATA_W up to MERGE_W can share it;
    // callers zero-extend operands and truncate the result.
    localparam int MERGE_W = 1024;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic int lsb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_B-1:0] strb
    );
        logic [MERGE_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MERGE_B; i++)
            if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// apb_mem_bank: DEPTH x DATA_W word storage, synchronous clear, byte-enabled write, out-of-range reads 0.
//   clk_i/rst_i   clock, synchronous active-high clear of every word
//   we_i          commit wdata_i into word widx_i under wstrb_i (dropped if out of range)
//   ridx_i        combinational read index; rdata_o is 0 when out of range
module apb_mem_bank
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [APB_ADDR_W-1:0] widx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [APB_ADDR_W-1:0] ridx_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              w_ok, r_ok;

    assign w_ok    = widx_i < APB_ADDR_W'(DEPTH);
    assign r_ok    = ridx_i < APB_ADDR_W'(DEPTH);
    assign rdata_o = r_ok ? mem_q[ridx_i[AW-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i && w_ok) begin
            mem_q[widx_i[AW-1:0]] <= DATA_W'(byte_merge(MERGE_W'(mem_q[widx_i[AW-1:0]]),
                                                        MERGE_W'(wdata_i), MERGE_B'(wstrb_i)));
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer over a word-organised register memory with WAIT_CYCLES wait states.
//   PCLK/PRESET        clock, synchronous active-high reset
//   PSEL/PENABLE       APB phase controls; PADDR byte address, PWRITE direction
//   PWDATA/PSTRB       write data and byte strobes
//   PRDATA/PREADY      read data (held from setup edge to next setup edge), transfer complete
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY
);

    localparam int LSB = lsb_of(DATA_W);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [APB_ADDR_W-1:0]   idx_q, idx_d, setup_idx;
    logic                    wr_q, wr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d, rdata_q, rdata_d, mem_rdata;
    logic [DATA_W/8-1:0]     strb_q, strb_d;
    logic                    commit;

    assign setup_idx = PADDR >> LSB;
    assign PRDATA    = rdata_q;
    // An aborted access (PSEL dropped) must not see PREADY even if the counter is spent.
    assign PREADY    = (state_q == ACCESS) && PSEL && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        if (state_q == IDLE) begin
            if (PSEL && !PENABLE) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_CYCLES);
                idx_d   = setup_idx;
                wr_d    = PWRITE;
                wdata_d = PWDATA;
                strb_d  = PSTRB;
                rdata_d = PWRITE ? '0 : mem_rdata;
            end
        end else if (!PSEL) begin
            state_d = IDLE;
        end else if (cnt_q == '0) begin
            state_d = IDLE;
            commit  = wr_q;
        end else if (PENABLE) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
        end
    end

    apb_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (commit),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .wstrb_i (strb_q),
        .ridx_i  (setup_idx),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed table-driven bench for apb_slave_mem (zero-wait and 2-wait instances).
module tb_apb_slave_mem;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        psel0 = 1'b0, psel2 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] rd0, rd2;
    logic        rdy0, rdy2;
    int          n_cmp = 0, n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rd0), .PREADY(rdy0));

    apb_slave_mem #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel2), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rd2), .PREADY(rdy2));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle;
        psel0 = 1'b0;
        psel2 = 1'b0;
        PENABLE = 1'b0;
        tick;
    endtask

    // Runs one transfer; returns PRDATA sampled while PREADY is high and the
    // number of cycles from the setup edge to the PREADY-high sample.
    task automatic xfer(input bit z, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        if (z) psel0 = 1'b1; else psel2 = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        PSTRB   = s;
        tick;
        PENABLE = 1'b1;
        lat = 1;
        while (!(z ? rdy0 : rdy2) && lat < 40) begin
            tick;
            lat++;
        end
        rd = z ? rd0 : rd2;
        tick;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;

        tbl[0]  = '{1'b1, 32'h020, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 32'h020, 32'h0,        4'hF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h030, 32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 32'h030, 32'hAABBCCDD, 4'h5, 32'h0};
        tbl[4]  = '{1'b0, 32'h030, 32'h0,        4'h0, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 32'h030, 32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[6]  = '{1'b0, 32'h030, 32'h0,        4'hF, 32'h11BB33DD};
        tbl[7]  = '{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0};
        tbl[8]  = '{1'b0, 32'h3FE, 32'h0,        4'hF, 32'h12345678};
        tbl[9]  = '{1'b1, 32'h000, 32'hA5A5A5A5, 4'hF, 32'h0};
        tbl[10] = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0};
        tbl[12] = '{1'b0, 32'h000, 32'h0,        4'hF, 32'hA5A5A5A5};

        psel2 = 1'b1;
        tick;
        tick;
        chk("rst_pready0", 32'(rdy0), 32'h0);
        chk("rst_prdata0", rd0, 32'h0);
        chk("rst_pready2", 32'(rdy2), 32'h0);
        chk("rst_prdata2", rd2, 32'h0);
        PRESET = 1'b0;
        idle;

        xfer(1'b1, 1'b0, 32'h010, 32'h0, 4'hF, rd, lat);
        chk("zw_read_data", rd, 32'h0);
        chk("zw_read_lat", 32'(lat), 32'd1);
        idle;

        for (int i = 0; i < 13; i++) begin
            xfer(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, rd, lat);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            idle;
        end

        xfer(1'b0, 1'b1, 32'h004, 32'h1, 4'hF, rd, lat);
        chk("b2b_w1_cycles", 32'(lat + 1), 32'd4);
        xfer(1'b0, 1'b1, 32'h008, 32'h2, 4'hF, rd, lat);
        chk("b2b_w2_cycles", 32'(lat + 1), 32'd4);
        xfer(1'b0, 1'b0, 32'h004, 32'h0, 4'hF, rd, lat);
        chk("b2b_r_cycles", 32'(lat + 1), 32'd4);
        chk("b2b_r_data", rd, 32'h1);
        idle;

        psel2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h040;
        PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        tick;
        PENABLE = 1'b1;
        chk("abort_wait_pready", 32'(rdy2), 32'h0);
        psel2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            seen = seen | rdy2;
        end
        chk("abort_no_pready", 32'(seen), 32'h0);
        idle;
        xfer(1'b0, 1'b0, 32'h040, 32'h0, 4'hF, rd, lat);
        chk("abort_read_data", rd, 32'h0);
        idle;

        xfer(1'b0, 1'b1, 32'h020, 32'hDEADBEEF, 4'hF, rd, lat);
        idle;
        psel2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h044;
        PWDATA = 32'h55; PSTRB = 4'hF;
        tick;
        PENABLE = 1'b1;
        tick;
        PRESET = 1'b1;
        tick;
        PRESET = 1'b0;
        chk("midrst_pready", 32'(rdy2), 32'h0);
        chk("midrst_prdata", rd2, 32'h0);
        tick;
        chk("midrst_idle_hold", 32'(rdy2), 32'h0);
        idle;
        xfer(1'b0, 1'b0, 32'h044, 32'h0, 4'hF, rd, lat);
        chk("midrst_no_write", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h020, 32'h0, 4'hF, rd, lat);
        chk("midrst_clear_20", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h3FC, 32'h0, 4'hF, rd, lat);
        chk("midrst_clear_3fc", rd, 32'h0);
        chk("midrst_read_lat", 32'(lat), 32'd3);
        idle;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave end of APB_if): byte-addressed, word-organised register memory.
- Used as the DUT/reference responder opposite the UVM APB master agent.
- Supports APB4 write strobes and a parameterised number of wait states via PREADY.
- Two-state FSM, wait counter and byte-enable storage.

Parameters:
- DATA_W, 32, data bus width in bits (multiple of 8).
- DEPTH, 256, number of DATA_W-bit words.
- WAIT_CYCLES, 2, wait states inserted in every access phase (0..15; 0 = zero-wait).

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  32  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DATA_W  write data.
- PSTRB  input  DATA_W/8  write byte strobes; bit i enables PWDATA[8i+7:8i].
- PRDATA  output  DATA_W  read data.
- PREADY  output  1  transfer-complete indicator.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset is PRESET, synchronous and active-high.
- Reset values: state = IDLE, wait counter = 0, PREADY = 0, PRDATA = 0, all memory words = 0.
- Address decode:
  - LSB = log2(DATA_W/8); word index = PADDR >> LSB.
  - Low LSB bits are ignored, so unaligned addresses alias to their word.
  - In range: index < DEPTH. Out of range: writes dropped, reads return 0. The transfer still completes normally.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when PSEL=1 and PENABLE=0 (setup phase).
  - On that edge: latch address, PWRITE, PWDATA and PSTRB; load counter = WAIT_CYCLES; load PRDATA = mem[idx] (0 if out of range, or if write).
  - IDLE with PSEL=1 and PENABLE=1 is a protocol violation: ignored, stays IDLE.
  - ACCESS, PSEL=1 and PENABLE=1, counter != 0: counter decrements, PREADY = 0.
  - ACCESS, counter == 0: PREADY = 1 (combinational from state and counter). On that edge, for a write, store latched data into mem[idx] per latched PSTRB. Next state is IDLE.
  - ACCESS with PSEL=0: abort. Return to IDLE, no write, PREADY = 0.
- Timing:
  - PREADY is high only in ACCESS with counter == 0. It is never high in IDLE.
  - Latency from setup edge to PREADY high is WAIT_CYCLES+1 cycles. WAIT_CYCLES = 0 gives the standard 2-cycle APB transfer.
- Back-to-back transfers: after completion the FSM is in IDLE. A new setup presented on that same cycle is accepted, so there are no extra idle cycles.
- PRDATA:
  - Holds its value from the setup edge until the next setup edge.
  - Valid whenever PREADY = 1 on a read.
  - Unaffected by writes.
- Write strobes:
  - PSTRB = 0 on a write: completes, memory unchanged.
  - PSTRB is ignored on reads.
- Mid-transfer changes: master-side changes to PADDR/PWDATA/PWRITE during ACCESS are ignored, because the values were latched at setup.
- Reset asserted mid-transfer: next state is IDLE, PREADY = 0, pending write discarded, memory cleared.
- Read after write to the same address in consecutive transfers returns the new data. The write commits before the next setup edge.

Decomposition:
- Package apb_pkg:
  - State typedef (IDLE, ACCESS).
  - APB_ADDR_W = 32.
  - Helper function for byte-lane merge (old word, new word, strobe → merged word).
  - Constant LSB derivation.
- Sub-module apb_mem_bank:
  - DEPTH × DATA_W storage.
  - Synchronous clear on reset.
  - Byte-enabled write port; read port with out-of-range → 0.
  - apb_slave_mem holds the FSM, counter and PREADY/PRDATA logic.

Test Plan:
- Reset then zero-wait read (WAIT_CYCLES=0): read 0x10 → PRDATA=0x00000000, PREADY high exactly 1 cycle after setup; PREADY=0 and PRDATA=0 during reset.
- Write/readback with WAIT_CYCLES=2: write 0x20 ← 0xDEADBEEF, PSTRB=0xF, then read 0x20 → PREADY low 2 access cycles, high on 3rd; PRDATA=0xDEADBEEF.
- Strobes: preload 0x30=0x11223344, write 0xAABBCCDD with PSTRB=0x5, read → 0x11BB33DD; PSTRB=0x0 write → word unchanged.
- Boundaries: write 0x3FC (last word, DEPTH=256) ← 0x12345678, read 0x3FE (unaligned) → 0x12345678; write 0x400 ← 0xFFFFFFFF, read 0x400 → 0, read 0x000 → unchanged, PREADY still asserted.
- Back-to-back: three consecutive transfers (W 0x04=1, W 0x08=2, R 0x04) with no idle cycles → each completes in WAIT_CYCLES+2 cycles; read returns 0x00000001.
- Abort/reset: drop PSEL during wait state of write 0x40 ← 0xCAFEF00D → no PREADY, read 0x40 = 0. Assert PRESET mid-access of a write → FSM IDLE next cycle, PREADY=0, memory all 0.
